// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and default sizes for the SPI burst transfer controller.
//   spi_state_t        : controller FSM state encoding
//   SPI_DWIDTH_DEF     : default word width (TX FIFO, RX FIFO, shift engine)
//   SPI_LEN_WIDTH_DEF  : default burst-length / remaining-counter width
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_DWIDTH_DEF    = 8;
    localparam int SPI_LEN_WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_STORE = 3'd4,
        ST_HOLD  = 3'd5
    } spi_state_t;

endpackage : spi_pkg

// File: rtl/spi_xfer_wdt.sv
// -----------------------------------------------------------------------------
// spi_xfer_wdt
// Shift-engine watchdog. Counts consecutive cycles with 'run' high and flags
// 'expired' on the WDT_CYCLES-th such cycle. The count restarts whenever
// 'run' drops, so every word gets a fresh budget. WDT_CYCLES must be >= 1.
// Ports:
//   clk     in  1  clock, rising edge
//   rst_n   in  1  asynchronous active-low reset
//   run     in  1  controller is waiting in SHIFT
//   expired out 1  budget used up in this cycle
// -----------------------------------------------------------------------------
module spi_xfer_wdt #(
    parameter int WDT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired
);

    localparam int            CW   = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(WDT_CYCLES - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (!run) begin
            cnt_reg <= '0;
        end else if (cnt_reg != LAST) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expired = run && (cnt_reg == LAST);

endmodule : spi_xfer_wdt

// File: rtl/spi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// spi_xfer_ctrl
// Burst controller between a TX FIFO, an SPI shift engine and an RX FIFO.
// One accepted START moves BURST_LEN words: pop TX word, load and start the
// shifter, capture the received word, push it into the RX FIFO. CS_N is held
// low for the whole burst plus CS_HOLD_CYC cycles (minimum one) afterwards.
//
// Optional feature: define SPI_XFER_WDT_EN to enable the SHIFT watchdog
// (spi_xfer_wdt). On timeout the burst aborts, ERR is set (sticky until the
// next accepted START), no RX push happens, and DONE still pulses.
// Without the macro ERR is tied low and SHIFT waits forever.
//
// Ports:
//   CLK, RESETn           clock / asynchronous active-low reset
//   START, BURST_LEN      burst request (BURST_LEN = 0 is ignored)
//   BUSY, DONE, ERR       status: not idle / burst-end pulse / watchdog abort
//   TX_EMPTY, TX_POP, TX_DATA     TX FIFO side (read data one cycle after pop)
//   RX_FULL, RX_PUSH, RX_DATA     RX FIFO side
//   SH_START, SH_DATA, SH_DONE, SH_RDATA   shift-engine handshake
//   CS_N                  chip select, active low
// -----------------------------------------------------------------------------
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DWIDTH      = SPI_DWIDTH_DEF,
    parameter int LEN_WIDTH   = SPI_LEN_WIDTH_DEF,
    parameter int CS_HOLD_CYC = 2,
    parameter int WDT_CYCLES  = 255
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 START,
    input  logic [LEN_WIDTH-1:0] BURST_LEN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR,
    input  logic                 TX_EMPTY,
    output logic                 TX_POP,
    input  logic [DWIDTH-1:0]    TX_DATA,
    input  logic                 RX_FULL,
    output logic                 RX_PUSH,
    output logic [DWIDTH-1:0]    RX_DATA,
    output logic                 SH_START,
    output logic [DWIDTH-1:0]    SH_DATA,
    input  logic                 SH_DONE,
    input  logic [DWIDTH-1:0]    SH_RDATA,
    output logic                 CS_N
);

    // A hold setting of 0 still gives one HOLD cycle.
    localparam int             HOLD_EFF  = (CS_HOLD_CYC < 1) ? 1 : CS_HOLD_CYC;
    localparam int             HCW       = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_EFF - 1);

    spi_state_t           state_reg;
    spi_state_t           state_next;
    logic [LEN_WIDTH-1:0] remaining_reg;
    logic [HCW-1:0]       hold_cnt_reg;
    logic [DWIDTH-1:0]    sh_data_reg;
    logic [DWIDTH-1:0]    rx_data_reg;
    logic                 sh_start_reg;
    logic                 done_reg;

    logic accept;
    logic wdt_expired;
    logic wdt_abort;
    logic hold_end;
    logic store_push;

    assign accept     = (state_reg == ST_IDLE) && START && (BURST_LEN != '0);
    assign hold_end   = (state_reg == ST_HOLD) && (hold_cnt_reg == HOLD_LAST);
    assign store_push = (state_reg == ST_STORE) && !RX_FULL;
    // A completion arriving on the last watchdog cycle still wins.
    assign wdt_abort  = (state_reg == ST_SHIFT) && !SH_DONE && wdt_expired;

`ifdef SPI_XFER_WDT_EN
    logic err_reg;

    spi_xfer_wdt #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_wdt (
        .clk     (CLK),
        .rst_n   (RESETn),
        .run     (state_reg == ST_SHIFT),
        .expired (wdt_expired)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            err_reg <= 1'b0;
        end else if (accept) begin
            err_reg <= 1'b0;
        end else if (wdt_abort) begin
            err_reg <= 1'b1;
        end
    end

    assign ERR = err_reg;
`else
    assign wdt_expired = 1'b0;
    assign ERR         = 1'b0;
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_FETCH;
            ST_FETCH: if (!TX_EMPTY) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (SH_DONE) begin
                    state_next = ST_STORE;
                end else if (wdt_abort) begin
                    state_next = ST_IDLE;
                end
            end
            ST_STORE: begin
                if (store_push) begin
                    state_next = (remaining_reg == LEN_WIDTH'(1)) ? ST_HOLD : ST_FETCH;
                end
            end
            ST_HOLD:  if (hold_end) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            remaining_reg <= '0;
            hold_cnt_reg  <= '0;
            sh_data_reg   <= '0;
            rx_data_reg   <= '0;
            sh_start_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            // TX_DATA is only valid in LOAD, so the shifter word and its start
            // strobe are both registered there and appear together in the
            // first SHIFT cycle.
            sh_start_reg <= (state_reg == ST_LOAD);
            done_reg     <= hold_end || wdt_abort;

            if (state_reg == ST_LOAD) begin
                sh_data_reg <= TX_DATA;
            end
            if ((state_reg == ST_SHIFT) && SH_DONE) begin
                rx_data_reg <= SH_RDATA;
            end

            if (accept) begin
                remaining_reg <= BURST_LEN;
            end else if (wdt_abort) begin
                remaining_reg <= '0;
            end else if (store_push) begin
                remaining_reg <= remaining_reg - 1'b1;
            end

            if (state_reg != ST_HOLD) begin
                hold_cnt_reg <= '0;
            end else if (!hold_end) begin
                hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        BUSY     = (state_reg != ST_IDLE);
        CS_N     = (state_reg == ST_IDLE);
        TX_POP   = (state_reg == ST_FETCH) && !TX_EMPTY;
        RX_PUSH  = store_push;
        SH_START = sh_start_reg;
        SH_DATA  = sh_data_reg;
        RX_DATA  = rx_data_reg;
        DONE     = done_reg;
    end

endmodule : spi_xfer_ctrl

// File: tb/tb_spi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_xfer_ctrl
// Directed bench for spi_xfer_ctrl with behavioural TX FIFO, 2-cycle loopback
// shifter and RX FIFO models. The SPI_XFER_WDT_EN sequence only runs when the
// macro is defined for the build.
// -----------------------------------------------------------------------------
module tb_spi_xfer_ctrl;

    localparam int DW   = 8;
    localparam int LW   = 4;
    localparam int HOLD = 2;
    localparam int WDT  = 10;

    logic          CLK = 1'b0;
    logic          RESETn;
    logic          START;
    logic [LW-1:0] BURST_LEN;
    logic          BUSY, DONE, ERR;
    logic          TX_EMPTY, TX_POP;
    logic [DW-1:0] TX_DATA;
    logic          RX_FULL, RX_PUSH;
    logic [DW-1:0] RX_DATA;
    logic          SH_START, SH_DONE;
    logic [DW-1:0] SH_DATA, SH_RDATA;
    logic          CS_N;

    always #5 CLK = ~CLK;

    spi_xfer_ctrl #(
        .DWIDTH      (DW),
        .LEN_WIDTH   (LW),
        .CS_HOLD_CYC (HOLD),
        .WDT_CYCLES  (WDT)
    ) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .START     (START),
        .BURST_LEN (BURST_LEN),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .TX_EMPTY  (TX_EMPTY),
        .TX_POP    (TX_POP),
        .TX_DATA   (TX_DATA),
        .RX_FULL   (RX_FULL),
        .RX_PUSH   (RX_PUSH),
        .RX_DATA   (RX_DATA),
        .SH_START  (SH_START),
        .SH_DATA   (SH_DATA),
        .SH_DONE   (SH_DONE),
        .SH_RDATA  (SH_RDATA),
        .CS_N      (CS_N)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------ models and monitor
    logic [7:0] tx_q[$];
    int  tx_stall_cfg = 0, rx_stall_cfg = 0;
    int  tx_stall_cnt = 0, rx_full_cnt = 0, sh_cnt = 0;
    bit  sh_en = 1'b1;
    logic [7:0] sh_cap = '0;
    bit  m_pop, m_shs, m_shd, m_push;
    logic [7:0] m_shdata;

    int  cyc = 0;
    int  n_pop, n_push, n_shs, n_done, n_ovl, n_csbad, n_bad, n_rxchg;
    int  pop_cyc[$], push_cyc[$], done_cyc[$], shs_cyc[$], lat_q[$];
    logic [7:0] rx_q[$], shd_q[$];
    int  last_shdone;
    bit  waiting;
    logic [7:0] prev_rxd;

    task automatic clear_stats();
        n_pop = 0; n_push = 0; n_shs = 0; n_done = 0;
        n_ovl = 0; n_csbad = 0; n_bad = 0; n_rxchg = 0;
        pop_cyc.delete(); push_cyc.delete(); done_cyc.delete();
        shs_cyc.delete(); lat_q.delete(); rx_q.delete(); shd_q.delete();
        tx_q.delete();
        waiting = 1'b0; last_shdone = 0;
        tx_stall_cfg = 0; rx_stall_cfg = 0;
    endtask

    always begin
        @(negedge CLK);
        cyc++;
        if (TX_POP) begin
            n_pop++; pop_cyc.push_back(cyc);
            if (TX_EMPTY) n_bad++;
        end
        if (SH_START) begin
            n_shs++; shd_q.push_back(SH_DATA); shs_cyc.push_back(cyc);
        end
        if (RX_PUSH) begin
            n_push++; rx_q.push_back(RX_DATA); push_cyc.push_back(cyc);
            lat_q.push_back(cyc - last_shdone); waiting = 1'b0;
            if (RX_FULL) n_bad++;
        end else if (waiting && (cyc > last_shdone + 1) && (RX_DATA != prev_rxd)) begin
            n_rxchg++;
        end
        if (SH_DONE) begin
            last_shdone = cyc; waiting = 1'b1;
        end
        prev_rxd = RX_DATA;
        if ((int'(TX_POP) + int'(RX_PUSH) + int'(SH_START)) > 1) n_ovl++;
        if (DONE) begin
            n_done++; done_cyc.push_back(cyc);
            if (BUSY) n_bad++;
        end
        if (BUSY == CS_N) n_csbad++;
        m_pop = TX_POP; m_shs = SH_START; m_shdata = SH_DATA;
        m_shd = SH_DONE; m_push = RX_PUSH;

        @(posedge CLK);
        #1;
        // TX FIFO: registered read data, optional empty window after word 1
        if (m_pop && (tx_q.size() > 0)) TX_DATA = tx_q.pop_front();
        if (m_push && (n_push == 1) && (tx_stall_cfg > 0)) tx_stall_cnt = tx_stall_cfg;
        TX_EMPTY = (tx_q.size() == 0) || (tx_stall_cnt > 0);
        if (tx_stall_cnt > 0) tx_stall_cnt--;
        // loopback shifter: SH_DONE two cycles after SH_START
        SH_DONE = 1'b0;
        if (sh_cnt > 0) begin
            sh_cnt--;
            if (sh_cnt == 0) begin
                SH_DONE = 1'b1; SH_RDATA = sh_cap;
            end
        end
        if (m_shs && sh_en) begin
            sh_cap = m_shdata; sh_cnt = 1;
        end
        // RX FIFO: full for rx_stall_cfg cycles of STORE
        if (m_shd && (rx_stall_cfg > 0)) rx_full_cnt = rx_stall_cfg;
        RX_FULL = (rx_full_cnt > 0);
        if (rx_full_cnt > 0) rx_full_cnt--;
    end

    // ------------------------------------------------------- helpers
    task automatic pulse_start(input int len);
        @(posedge CLK); #1;
        START = 1'b1; BURST_LEN = LW'(len);
        @(posedge CLK); #1;
        START = 1'b0; BURST_LEN = 4'hF;
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (n_done > 0) begin ok = 1'b1; break; end
        end
        if (!ok) chk({name, "_timeout"}, 0, 1);
        repeat (3) @(negedge CLK);
    endtask

    task automatic wait_shs(input int n, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (n_shs >= n) begin ok = 1'b1; break; end
        end
        if (!ok) chk({name, "_timeout"}, 0, 1);
    endtask

    function automatic longint qb(input logic [7:0] q[$], input int k);
        return (k < q.size()) ? longint'(q[k]) : -1;
    endfunction

    function automatic longint qi(input int q[$], input int k);
        return (k < q.size()) ? longint'(q[k]) : -1000;
    endfunction

    // --------------------------------------------------------- vectors
    typedef struct {
        int          len;
        logic [23:0] words;
        int          tx_stall;
        int          rx_stall;
        int          exp_first;  // FETCH entry to RX_PUSH, word 1
        int          exp_gap;    // TX_POP word 1 to TX_POP word 2
        int          exp_lat;    // SH_DONE to RX_PUSH
    } vec_t;

    vec_t vecs[4];

    initial begin
        RESETn = 1'b0; START = 1'b0; BURST_LEN = '0;
        TX_EMPTY = 1'b1; TX_DATA = '0; RX_FULL = 1'b0;
        SH_DONE = 1'b0; SH_RDATA = '0;
        clear_stats();

        vecs[0] = '{3, 24'hC3B2A1, 0, 0, 5, 6, 1};
        vecs[1] = '{2, 24'h002211, 5, 0, 5, 11, 1};
        vecs[2] = '{1, 24'h00005A, 0, 4, 9, 0, 5};
        vecs[3] = '{2, 24'h007E3C, 0, 1, 6, 7, 2};

        // reset values
        repeat (3) @(negedge CLK);
        chk("rst_busy", BUSY, 0);      chk("rst_cs_n", CS_N, 1);
        chk("rst_done", DONE, 0);      chk("rst_err", ERR, 0);
        chk("rst_tx_pop", TX_POP, 0);  chk("rst_rx_push", RX_PUSH, 0);
        chk("rst_sh_start", SH_START, 0);
        chk("rst_sh_data", SH_DATA, 0); chk("rst_rx_data", RX_DATA, 0);
        @(posedge CLK); #1; RESETn = 1'b1;
        repeat (2) @(negedge CLK);

        // table-driven bursts
        for (int i = 0; i < 4; i++) begin
            clear_stats();
            tx_stall_cfg = vecs[i].tx_stall;
            rx_stall_cfg = vecs[i].rx_stall;
            for (int k = 0; k < vecs[i].len; k++) tx_q.push_back(vecs[i].words[8*k +: 8]);
            repeat (2) @(negedge CLK);
            pulse_start(vecs[i].len);
            wait_done($sformatf("v%0d", i));
            $display("vec %0d: len=%0d pops=%0d pushes=%0d sh_starts=%0d done=%0d",
                     i, vecs[i].len, n_pop, n_push, n_shs, n_done);
            chk($sformatf("v%0d_pops", i), n_pop, vecs[i].len);
            chk($sformatf("v%0d_pushes", i), n_push, vecs[i].len);
            chk($sformatf("v%0d_sh_starts", i), n_shs, vecs[i].len);
            chk($sformatf("v%0d_done", i), n_done, 1);
            chk($sformatf("v%0d_overlap", i), n_ovl, 0);
            chk($sformatf("v%0d_cs_n", i), n_csbad, 0);
            chk($sformatf("v%0d_protocol", i), n_bad, 0);
            chk($sformatf("v%0d_rx_stable", i), n_rxchg, 0);
            chk($sformatf("v%0d_err", i), ERR, 0);
            chk($sformatf("v%0d_busy_end", i), BUSY, 0);
            for (int k = 0; k < vecs[i].len; k++) begin
                chk($sformatf("v%0d_sh_data%0d", i, k), qb(shd_q, k), vecs[i].words[8*k +: 8]);
                chk($sformatf("v%0d_rx_data%0d", i, k), qb(rx_q, k), vecs[i].words[8*k +: 8]);
                chk($sformatf("v%0d_lat%0d", i, k), qi(lat_q, k), vecs[i].exp_lat);
            end
            chk($sformatf("v%0d_first", i), qi(push_cyc, 0) - qi(pop_cyc, 0), vecs[i].exp_first);
            if (vecs[i].len > 1)
                chk($sformatf("v%0d_gap", i), qi(pop_cyc, 1) - qi(pop_cyc, 0), vecs[i].exp_gap);
            chk($sformatf("v%0d_hold", i),
                qi(done_cyc, 0) - qi(push_cyc, vecs[i].len - 1), HOLD + 1);
        end

        // BURST_LEN = 0 is ignored
        clear_stats();
        tx_q.push_back(8'h99);
        repeat (2) @(negedge CLK);
        pulse_start(0);
        repeat (5) @(negedge CLK);
        $display("zero-len: busy=%0d pops=%0d", BUSY, n_pop);
        chk("zero_busy", BUSY, 0); chk("zero_cs_n", CS_N, 1);
        chk("zero_pops", n_pop, 0); chk("zero_done", n_done, 0);

        // START while busy is ignored, BURST_LEN not resampled
        clear_stats();
        for (int k = 1; k <= 6; k++) tx_q.push_back(8'(k));
        repeat (2) @(negedge CLK);
        pulse_start(2);
        wait_shs(1, "busy_start");
        chk("busy_pre", BUSY, 1);
        pulse_start(5);
        wait_done("busy_start");
        $display("start-while-busy: pops=%0d pushes=%0d done=%0d", n_pop, n_push, n_done);
        chk("busy_pops", n_pop, 2); chk("busy_pushes", n_push, 2);
        chk("busy_done", n_done, 1); chk("busy_rx1", qb(rx_q, 1), 8'h02);

        // maximum burst length, no wrap of the remaining counter
        clear_stats();
        for (int k = 0; k < 15; k++) tx_q.push_back(8'(8'h10 + k));
        repeat (2) @(negedge CLK);
        pulse_start(15);
        wait_done("max_len");
        $display("max-len: pops=%0d pushes=%0d done=%0d", n_pop, n_push, n_done);
        chk("max_pushes", n_push, 15); chk("max_done", n_done, 1);
        chk("max_rx14", qb(rx_q, 14), 8'h1E); chk("max_cs_n", n_csbad, 0);

        // reset in SHIFT of word 2 of 4
        clear_stats();
        for (int k = 0; k < 4; k++) tx_q.push_back(8'(8'h40 + k));
        repeat (2) @(negedge CLK);
        pulse_start(4);
        wait_shs(2, "rst_mid");
        chk("rstm_busy_pre", BUSY, 1);
        #2 RESETn = 1'b0;
        #1;
        chk("rstm_busy", BUSY, 0);       chk("rstm_cs_n", CS_N, 1);
        chk("rstm_sh_start", SH_START, 0); chk("rstm_tx_pop", TX_POP, 0);
        chk("rstm_rx_push", RX_PUSH, 0); chk("rstm_sh_data", SH_DATA, 0);
        chk("rstm_rx_data", RX_DATA, 0); chk("rstm_done", DONE, 0);
        repeat (3) @(posedge CLK);
        #1 RESETn = 1'b1;
        repeat (10) @(negedge CLK);
        $display("reset-mid: pushes=%0d done=%0d busy=%0d", n_push, n_done, BUSY);
        chk("rstm_no_done", n_done, 0); chk("rstm_pushes", n_push, 1);
        chk("rstm_idle", BUSY, 0);

`ifdef SPI_XFER_WDT_EN
        // watchdog abort, then ERR cleared by the next accepted START
        clear_stats();
        sh_en = 1'b0;
        tx_q.push_back(8'h77);
        repeat (2) @(negedge CLK);
        pulse_start(1);
        wait_done("wdt");
        $display("wdt: err=%0d pushes=%0d done=%0d", ERR, n_push, n_done);
        chk("wdt_err", ERR, 1); chk("wdt_pushes", n_push, 0);
        chk("wdt_done", n_done, 1); chk("wdt_cs_n", CS_N, 1);
        chk("wdt_cycles", qi(done_cyc, 0) - qi(shs_cyc, 0), WDT);
        clear_stats();
        sh_en = 1'b1;
        tx_q.push_back(8'h88);
        repeat (2) @(negedge CLK);
        chk("wdt_err_sticky", ERR, 1);
        pulse_start(1);
        wait_done("wdt_clear");
        $display("wdt-clear: err=%0d pushes=%0d", ERR, n_push);
        chk("wdt_err_clear", ERR, 0); chk("wdt_clear_push", n_push, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule : tb_spi_xfer_ctrl
